cr_huf_comp_sc_pack: RTL

// - Transmit side of the sc->is symbol/count interface: turns a 1-symbol/cycle stream into
//   run-length (sym,cnt) entries, 4 lanes/beat, on sc_is_*; is_sc_rd is the read strobe.
// - Sits between the symbol source and cr_huf_comp_is_counter; one e_pipe_eob-terminated burst per block.

---
 rtl/cr_huf_comp_sc_pack.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cr_huf_comp_sc_pack.sv
// cr_huf_comp_sc_pack: run-length symbol/count packer for the sc->is interface.
// Turns a one-symbol-per-cycle block stream into (sym,cnt) runs and emits them
// four lanes per beat. The final beat of each block is marked with the eob encoding.
// Optional feature: define CR_HUF_COMP_SC_PACK_STATS_EN to add the per-block
// symbol statistics ports stat_sym_cnt / stat_blk_done.

`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 4
`endif

package cr_huf_comp_sc_pack_pkg;

  localparam int unsigned SEQID_WIDTH = `CREOLE_HC_SEQID_WIDTH;

  // End-of-block marker carried with every beat
  typedef enum logic [1:0] {
    PIPE_NEOB = 2'd0,
    PIPE_EOB  = 2'd3
  } e_pipe_eob;

endpackage

module cr_huf_comp_sc_pack
  import cr_huf_comp_sc_pack_pkg::*;
#(
  parameter int unsigned DAT_WIDTH   = 10,
  parameter int unsigned CNT_WIDTH   = 3,
  parameter int unsigned CNTRL_WIDTH = 1,
  parameter int unsigned NUM_LANES   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [DAT_WIDTH-1:0]   in_sym,
  input  logic                   in_last,
  input  logic [CNTRL_WIDTH-1:0] in_meta,
  input  logic [SEQID_WIDTH-1:0] in_seq_id,
  output logic [3:0]             sc_is_vld,
  output logic [DAT_WIDTH-1:0]   sc_is_sym0,
  output logic [DAT_WIDTH-1:0]   sc_is_sym1,
  output logic [DAT_WIDTH-1:0]   sc_is_sym2,
  output logic [DAT_WIDTH-1:0]   sc_is_sym3,
  output logic [CNT_WIDTH-1:0]   sc_is_cnt0,
  output logic [CNT_WIDTH-1:0]   sc_is_cnt1,
  output logic [CNT_WIDTH-1:0]   sc_is_cnt2,
  output logic [CNT_WIDTH-1:0]   sc_is_cnt3,
  output logic [CNTRL_WIDTH-1:0] sc_is_meta,
  output logic [SEQID_WIDTH-1:0] sc_is_seq_id,
  output e_pipe_eob              sc_is_eob,
  input  logic                   is_sc_rd
`ifdef CR_HUF_COMP_SC_PACK_STATS_EN
  ,
  output logic [15:0]            stat_sym_cnt,
  output logic                   stat_blk_done
`endif
);

  localparam int unsigned LANE_N_W = 3;
  localparam int unsigned SUM_W    = CNT_WIDTH + 3;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic                   rdy_en_q;

  // Open run
  logic [DAT_WIDTH-1:0]   cur_sym_q;
  logic [CNT_WIDTH-1:0]   cur_cnt_q;
  logic [CNTRL_WIDTH-1:0] blk_meta_q;
  logic [SEQID_WIDTH-1:0] blk_seq_q;

  // Packer
  logic [DAT_WIDTH-1:0]   pk_sym_q [4];
  logic [CNT_WIDTH-1:0]   pk_cnt_q [4];
  logic [LANE_N_W-1:0]    pk_n_q;
  logic [LANE_N_W-1:0]    pk_base;

  // Output beat
  logic [DAT_WIDTH-1:0]   out_sym_q [4];
  logic [CNT_WIDTH-1:0]   out_cnt_q [4];
  logic [3:0]             out_vld_q;
  logic [CNTRL_WIDTH-1:0] out_meta_q;
  logic [SEQID_WIDTH-1:0] out_seq_q;
  e_pipe_eob              out_eob_q;

  // Control
  logic out_busy;
  logic beat_rd;
  logic drain_ok;
  logic pk_full;
  logic run_open;
  logic sym_match;
  logic rdy_c;
  logic in_acc;
  logic blk_start;
  logic run_start;
  logic run_close;
  logic pk_move;
  logic pk_eob;

  assign out_busy  = |out_vld_q;
  assign beat_rd   = out_busy & is_sc_rd;
  assign drain_ok  = ~out_busy | is_sc_rd;
  assign pk_full   = (pk_n_q == LANE_N_W'(NUM_LANES));
  assign run_open  = (cur_cnt_q != '0);
  assign sym_match = (in_sym == cur_sym_q) && (cur_cnt_q != CNT_MAX);
  assign pk_base   = pk_move ? '0 : pk_n_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Next state, input handshake and run/packer/output control strobes
  always_comb begin
    state_d   = state_q;
    rdy_c     = 1'b0;
    in_acc    = 1'b0;
    blk_start = 1'b0;
    run_start = 1'b0;
    run_close = 1'b0;
    pk_move   = 1'b0;
    pk_eob    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        rdy_c  = rdy_en_q;
        in_acc = in_vld & rdy_c;
        if (in_acc) begin
          blk_start = 1'b1;
          run_start = 1'b1;
          state_d   = in_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        // A mismatching symbol may close into a full packer only while it drains
        rdy_c   = ~pk_full | drain_ok;
        in_acc  = in_vld & rdy_c;
        pk_move = pk_full & drain_ok;
        if (in_acc) begin
          if (!sym_match) begin
            run_close = 1'b1;
            run_start = 1'b1;
          end
          if (in_last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (run_open) begin
          pk_move   = pk_full & drain_ok;
          run_close = ~pk_full | drain_ok;
        end else begin
          pk_move = drain_ok;
          pk_eob  = drain_ok;
          if (drain_ok) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run stage: extend, restart or close the current run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sym_q <= '0;
      cur_cnt_q <= '0;
    end else if (run_start) begin
      cur_sym_q <= in_sym;
      cur_cnt_q <= CNT_ONE;
    end else if (in_acc) begin
      cur_cnt_q <= cur_cnt_q + CNT_ONE;
    end else if (run_close) begin
      cur_cnt_q <= '0;
    end
  end

  // Block meta/seq_id captured with the first symbol of each block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_meta_q <= '0;
      blk_seq_q  <= '0;
    end else if (blk_start) begin
      blk_meta_q <= in_meta;
      blk_seq_q  <= in_seq_id;
    end
  end

  // Packer: closed runs land in the next free lane, emptied when moved out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_n_q <= '0;
      for (int i = 0; i < 4; i++) begin
        pk_sym_q[i] <= '0;
        pk_cnt_q[i] <= '0;
      end
    end else begin
      pk_n_q <= run_close ? pk_base + LANE_N_W'(1) : pk_base;
      if (run_close) begin
        pk_sym_q[pk_base[1:0]] <= cur_sym_q;
        pk_cnt_q[pk_base[1:0]] <= cur_cnt_q;
      end
    end
  end

  // Output beat register: load from packer, clear once read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= '0;
      out_meta_q <= '0;
      out_seq_q  <= '0;
      out_eob_q  <= PIPE_NEOB;
      for (int i = 0; i < 4; i++) begin
        out_sym_q[i] <= '0;
        out_cnt_q[i] <= '0;
      end
    end else if (pk_move) begin
      out_meta_q <= blk_meta_q;
      out_seq_q  <= blk_seq_q;
      out_eob_q  <= pk_eob ? PIPE_EOB : PIPE_NEOB;
      for (int i = 0; i < 4; i++) begin
        if (LANE_N_W'(i) < pk_n_q) begin
          out_vld_q[i] <= 1'b1;
          out_sym_q[i] <= pk_sym_q[i];
          out_cnt_q[i] <= pk_cnt_q[i];
        end else begin
          out_vld_q[i] <= 1'b0;
          out_sym_q[i] <= '0;
          out_cnt_q[i] <= '0;
        end
      end
    end else if (beat_rd) begin
      out_vld_q  <= '0;
      out_meta_q <= '0;
      out_seq_q  <= '0;
      out_eob_q  <= PIPE_NEOB;
      for (int i = 0; i < 4; i++) begin
        out_sym_q[i] <= '0;
        out_cnt_q[i] <= '0;
      end
    end
  end

  assign in_rdy       = rdy_c;
  assign sc_is_vld    = out_vld_q;
  assign sc_is_sym0   = out_sym_q[0];
  assign sc_is_sym1   = out_sym_q[1];
  assign sc_is_sym2   = out_sym_q[2];
  assign sc_is_sym3   = out_sym_q[3];
  assign sc_is_cnt0   = out_cnt_q[0];
  assign sc_is_cnt1   = out_cnt_q[1];
  assign sc_is_cnt2   = out_cnt_q[2];
  assign sc_is_cnt3   = out_cnt_q[3];
  assign sc_is_meta   = out_meta_q;
  assign sc_is_seq_id = out_seq_q;
  assign sc_is_eob    = out_eob_q;

`ifdef CR_HUF_COMP_SC_PACK_STATS_EN
  logic [SUM_W-1:0] beat_sum;
  logic [15:0]      stat_base;
  logic [16:0]      stat_sum;
  logic [15:0]      stat_d;

  // Run-count total of the beat currently on the output
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (out_vld_q[i]) beat_sum = beat_sum + SUM_W'(out_cnt_q[i]);
    end
  end

  // Saturating block accumulator, restarted after the block total was shown
  always_comb begin
    stat_base = stat_blk_done ? '0 : stat_sym_cnt;
    stat_sum  = {1'b0, stat_base} + 17'(beat_sum);
    stat_d    = stat_base;
    if (beat_rd) stat_d = stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
  end

  // Statistics registers; block-done pulses after the eob beat is read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sym_cnt  <= '0;
      stat_blk_done <= 1'b0;
    end else begin
      stat_sym_cnt  <= stat_d;
      stat_blk_done <= beat_rd && (out_eob_q == PIPE_EOB);
    end
  end
`endif

endmodule
